pc_unit: RTL

- Parametrised program-counter unit for the single-cycle/pipelined datapath; successor to the fixed 32-bit PC register.
- Holds the current fetch address, computes sequential next PC internally, and accepts stall, branch/jump redirect, call and return.
- Contains a small circular return-address stack (RAS). Out-of-range addresses wrap to the reset vector.
- Feeds instruction-memory address directly.

---
 rtl/pc_if.sv | 43 ++++
 rtl/pc_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pc_if.sv
// ============================================================================
// Module      : pc_if
// Description : Control and status bundle between fetch control and pc_unit.
//               MisalignTrap exists only when PC_MISALIGN_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             Redirect;
    logic             Call;
    logic             Ret;
    logic [WIDTH-1:0] Target;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PCPlus;
    logic             RasEmpty;
    logic             RasFull;
    logic             RasUnderflow;
`ifdef PC_MISALIGN_TRAP_EN
    logic             MisalignTrap;
`endif

    modport master (
        output Stall, Redirect, Call, Ret, Target,
`ifdef PC_MISALIGN_TRAP_EN
        input  MisalignTrap,
`endif
        input  PC, PCPlus, RasEmpty, RasFull, RasUnderflow
    );

    modport slave (
        input  Stall, Redirect, Call, Ret, Target,
`ifdef PC_MISALIGN_TRAP_EN
        output MisalignTrap,
`endif
        output PC, PCPlus, RasEmpty, RasFull, RasUnderflow
    );
endinterface

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : Program counter with redirect/call/return and a circular
//               return-address stack. Optional macro: PC_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter int          WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] PC_LIMIT  = 116,
    parameter int          STEP      = 4,
    parameter int          RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] TRAP_VEC  = '0
) (
    input  wire logic Clk,
    input  wire logic Reset,
    pc_if.slave       bus
);
    localparam int                c_PTR_W = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W+1)'(RAS_DEPTH);

    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_underflow;

    logic [WIDTH-1:0]   w_pcplus;
    logic [WIDTH-1:0]   w_cand;
    logic [WIDTH-1:0]   w_next_pc;
    logic [c_PTR_W-1:0] w_ptr_inc;
    logic [c_PTR_W-1:0] w_ptr_dec;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_uf_set;
    logic               w_misalign;
    logic               w_trap;

    assign w_pcplus  = r_pc + WIDTH'(STEP);
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);

`ifdef PC_MISALIGN_TRAP_EN
    assign w_misalign = (bus.Target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Priority: Stall > Ret > Call > Redirect > sequential.
    always_comb begin
        w_cand   = w_pcplus;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_uf_set = 1'b0;
        w_trap   = 1'b0;
        if (bus.Stall) begin
            w_cand = r_pc;
        end else if (bus.Ret) begin
            if (w_empty) begin
                w_cand   = RESET_VEC;
                w_uf_set = 1'b1;
            end else begin
                w_cand = r_ras[r_ptr];
                w_pop  = 1'b1;
            end
        end else if (bus.Call || bus.Redirect) begin
            if (w_misalign) begin
                w_cand = TRAP_VEC;
                w_trap = 1'b1;
            end else begin
                w_cand = bus.Target;
                w_push = bus.Call;
            end
        end
    end

    assign w_next_pc = (w_cand > PC_LIMIT) ? RESET_VEC : w_cand;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc        <= RESET_VEC;
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (!bus.Stall) begin
            r_pc <= w_next_pc;
            if (w_push) begin
                // A full stack overwrites its oldest slot; count saturates.
                r_ras[w_ptr_inc] <= w_pcplus;
                r_ptr            <= w_ptr_inc;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - 1'b1;
            end
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic r_trap;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_trap;
        end
    end

    assign bus.MisalignTrap = r_trap;
`endif

    assign bus.PC           = r_pc;
    assign bus.PCPlus       = w_pcplus;
    assign bus.RasEmpty     = w_empty;
    assign bus.RasFull      = w_full;
    assign bus.RasUnderflow = r_underflow;

endmodule

`default_nettype wire
